icache_fill: RTL

- Refill (write-side) engine for the direct-mapped instruction cache array.
- On a fetch miss, it requests a whole line from the memory bus and streams the returned words into the cache data write port. It then commits the tag/valid entry.
- It also performs a whole-cache invalidate (flush) by sweeping every line's valid bit to 0.

---
 rtl/icache_fill.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/icache_fill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_fill
//  Description : Refill engine for a direct-mapped instruction cache.
//                On a fetch miss it requests one whole line from the memory
//                bus. It writes each returned word into the cache data array,
//                then commits the tag/valid entry. A flush request clears
//                every line's valid bit, one line per cycle.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n            clock / synchronous active-low reset
//    miss_valid/addr/ready miss handshake (byte PC of missing instruction)
//    flush                 one-cycle invalidate-all request
//    mem_req/addr/gnt      line read request to the memory bus
//    mem_rvalid/rdata      read beats, in ascending word order
//    wr_en/idx/data        cache data-array write port
//    tag_we/idx/val/vld    tag-array write port
//    fill_done             one-cycle pulse when a line is committed
//    busy                  engine not idle
// ============================================================================
module icache_fill #(
    parameter int DEPTH      = 128,
    parameter int LINE_WORDS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            miss_valid,
    input  logic [31:0]                     miss_addr,
    output logic                            miss_ready,
    input  logic                            flush,
    output logic                            mem_req,
    output logic [31:0]                     mem_addr,
    input  logic                            mem_gnt,
    input  logic                            mem_rvalid,
    input  logic [31:0]                     mem_rdata,
    output logic                            wr_en,
    output logic [$clog2(DEPTH)-1:0]        wr_idx,
    output logic [31:0]                     wr_data,
    output logic                            tag_we,
    output logic [$clog2(DEPTH)-$clog2(LINE_WORDS)-1:0] tag_idx,
    output logic [30-$clog2(DEPTH)-1:0]     tag_val,
    output logic                            tag_vld,
    output logic                            fill_done,
    output logic                            busy
);

    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int LW = IW - OW;
    localparam int TW = 30 - IW;

    localparam logic [OW-1:0] c_last_beat = {OW{1'b1}};
    localparam logic [LW-1:0] c_last_line = {LW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_RECV   = 3'd2,
        S_COMMIT = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t          r_state;
    logic [LW-1:0]   r_line;
    logic [TW-1:0]   r_tag;
    logic [31:0]     r_addr;
    logic [OW-1:0]   r_beat;
    logic [LW-1:0]   r_fcnt;
    logic            r_flush_pend;

    logic            w_accept;
    logic            w_unused;

    // Byte offset and in-line word offset of the PC are not needed: the
    // whole line is fetched starting from word 0.
    assign w_unused = ^miss_addr[OW+1:0];

    // A flush in the same cycle wins over a miss, so the miss is not
    // acknowledged in that cycle.
    assign miss_ready = (r_state == S_IDLE) && !flush;
    assign w_accept   = miss_valid && miss_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_line       <= '0;
            r_tag        <= '0;
            r_addr       <= '0;
            r_beat       <= '0;
            r_fcnt       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_fcnt  <= '0;
                        r_state <= S_FLUSH;
                    end else if (w_accept) begin
                        r_line  <= miss_addr[IW+1:OW+2];
                        r_tag   <= miss_addr[31:IW+2];
                        r_addr  <= {miss_addr[31:OW+2], {(OW+2){1'b0}}};
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_gnt) begin
                        r_beat  <= '0;
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == c_last_beat) begin
                            r_state <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    // A flush arriving in this very cycle still counts.
                    if (flush || r_flush_pend) begin
                        r_flush_pend <= 1'b0;
                        r_fcnt       <= '0;
                        r_state      <= S_FLUSH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    // Further flush requests are absorbed by the running sweep.
                    r_fcnt <= r_fcnt + 1'b1;
                    if (r_fcnt == c_last_line) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory request side
    assign mem_req  = (r_state == S_REQ);
    assign mem_addr = r_addr;

    // Data beats pass straight through to the array in the cycle they arrive.
    assign wr_en   = (r_state == S_RECV) && mem_rvalid;
    assign wr_idx  = {r_line, r_beat};
    assign wr_data = mem_rdata;

    // Tag port: commit writes a valid entry, sweep writes invalid ones.
    assign tag_we    = (r_state == S_COMMIT) || (r_state == S_FLUSH);
    assign tag_idx   = (r_state == S_FLUSH) ? r_fcnt : ((r_state == S_COMMIT) ? r_line : '0);
    assign tag_val   = (r_state == S_COMMIT) ? r_tag : '0;
    assign tag_vld   = (r_state == S_COMMIT);
    assign fill_done = (r_state == S_COMMIT);
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
